// File: rtl/cla_pkg.sv
// ============================================================================
// Module   : cla_pkg
// Purpose  : Shared constants, the group {g,p} type and the group G/P helper
//            for the pipelined carry-lookahead adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cla_pkg;

    localparam int GROUP_W = 4;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic gp_t group_gp(input logic [GROUP_W-1:0] g,
                                     input logic [GROUP_W-1:0] p);
        gp_t r;
        r.g = g[3]
            | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
        r.p = &p;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cla_group4.sv
// ============================================================================
// Module   : cla_group4
// Purpose  : Combinational 4-bit carry-lookahead group: sum plus group G/P.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] i_a,
    input  logic [GROUP_W-1:0] i_b,
    input  logic               i_cin,
    output logic [GROUP_W-1:0] o_sum,
    output gp_t                o_gp
);

    logic [GROUP_W-1:0] w_g;
    logic [GROUP_W-1:0] w_p;
    logic [GROUP_W-1:0] w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a | i_b;

    // Every bit carry is a flat function of i_cin and the bit g/p terms.
    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_cin);

    assign o_sum = i_a ^ i_b ^ w_c;
    assign o_gp  = group_gp(w_g, w_p);

endmodule

`default_nettype wire

// File: rtl/cla_pipe_adder.sv
// ============================================================================
// Module   : cla_pipe_adder
// Purpose  : Pipelined carry-lookahead adder with valid/ready backpressure.
//            Optional macro CLA_SUBTRACT_EN adds the sub port (a - b).
// Revision : 1.0
// ============================================================================
`default_nettype none

module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
`ifdef CLA_SUBTRACT_EN
    ,
    input  logic             sub
`endif
);

    localparam int c_groups = WIDTH / GROUP_W;
    localparam int c_gps    = c_groups / STAGES;
    localparam int c_sw     = c_gps * GROUP_W;
    localparam int c_last   = STAGES - 1;

    logic             w_adv;
    logic [WIDTH-1:0] w_b0;
    logic             w_c0;

    logic [WIDTH-1:0] w_a_in   [STAGES];
    logic [WIDTH-1:0] w_b_in   [STAGES];
    logic [WIDTH-1:0] w_sum_in [STAGES];
    logic             w_cin    [STAGES];
    logic             w_v_in   [STAGES];
    logic [WIDTH-1:0] w_sum_nx [STAGES];
    logic             w_cout   [STAGES];
    logic             w_ovf_nx;

    logic [WIDTH-1:0] r_a      [STAGES];
    logic [WIDTH-1:0] r_b      [STAGES];
    logic [WIDTH-1:0] r_sum    [STAGES];
    logic             r_carry  [STAGES];
    logic             r_valid  [STAGES];
    logic             r_ovf;

`ifdef CLA_SUBTRACT_EN
    assign w_b0 = sub ? ~b : b;
    assign w_c0 = c_in ^ sub;
`else
    assign w_b0 = b;
    assign w_c0 = c_in;
`endif

    assign w_adv    = ~r_valid[c_last] | out_ready;
    assign in_ready = w_adv;

    genvar k, j;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            localparam int c_lo = k * c_sw;

            gp_t              w_gp [c_gps];
            logic [c_gps:0]   w_gc;
            logic [c_sw-1:0]  w_ssum;

            if (k == 0) begin : g_first
                assign w_a_in[k]   = a;
                assign w_b_in[k]   = w_b0;
                assign w_sum_in[k] = '0;
                assign w_cin[k]    = w_c0;
                assign w_v_in[k]   = in_valid;
            end else begin : g_next
                assign w_a_in[k]   = r_a[k-1];
                assign w_b_in[k]   = r_b[k-1];
                assign w_sum_in[k] = r_sum[k-1];
                assign w_cin[k]    = r_carry[k-1];
                assign w_v_in[k]   = r_valid[k-1];
            end

            for (j = 0; j < c_gps; j++) begin : g_group
                cla_group4 u_group (
                    .i_a   (w_a_in[k][c_lo + j*GROUP_W +: GROUP_W]),
                    .i_b   (w_b_in[k][c_lo + j*GROUP_W +: GROUP_W]),
                    .i_cin (w_gc[j]),
                    .o_sum (w_ssum[j*GROUP_W +: GROUP_W]),
                    .o_gp  (w_gp[j])
                );
            end

            // Group carry j as a sum of products over the stage carry-in and
            // the group G/P terms below it, so there is no group-to-group ripple.
            always_comb begin
                logic w_acc;
                logic w_term;
                w_gc = '0;
                for (int n = 0; n <= c_gps; n++) begin
                    w_acc = w_cin[k];
                    for (int m = 0; m < n; m++) begin
                        w_acc = w_acc & w_gp[m].p;
                    end
                    for (int i = 0; i < n; i++) begin
                        w_term = w_gp[i].g;
                        for (int m = i + 1; m < n; m++) begin
                            w_term = w_term & w_gp[m].p;
                        end
                        w_acc = w_acc | w_term;
                    end
                    w_gc[n] = w_acc;
                end
            end

            assign w_cout[k]   = w_gc[c_gps];
            assign w_sum_nx[k] = w_sum_in[k] | (WIDTH'(w_ssum) << c_lo);
        end
    endgenerate

    // Carry into the MSB is recovered from its sum bit: c = a ^ b ^ s.
    assign w_ovf_nx = w_a_in[c_last][WIDTH-1] ^ w_b_in[c_last][WIDTH-1]
                    ^ w_sum_nx[c_last][WIDTH-1] ^ w_cout[c_last];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                r_valid[s] <= 1'b0;
                r_a[s]     <= '0;
                r_b[s]     <= '0;
                r_sum[s]   <= '0;
                r_carry[s] <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            for (int s = 0; s < STAGES; s++) begin
                r_valid[s] <= w_v_in[s];
                r_a[s]     <= w_a_in[s];
                r_b[s]     <= w_b_in[s];
                r_sum[s]   <= w_sum_nx[s];
                r_carry[s] <= w_cout[s];
            end
            r_ovf <= w_ovf_nx;
        end
    end

    assign out_valid = r_valid[c_last];
    assign sum       = r_sum[c_last];
    assign c_out     = r_carry[c_last];
    assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
// ============================================================================
// Module   : tb_cla_pipe_adder
// Purpose  : Scoreboard bench for cla_pipe_adder (WIDTH=16, STAGES=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cla_pipe_adder;

    localparam int WIDTH  = 16;
    localparam int STAGES = 2;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b1;
    logic             c_in      = 1'b0;
    logic             sub       = 1'b0;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int unsigned      cyc;
        int unsigned      stl;
    } exp_t;

    exp_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    int unsigned stalls   = 0;
    logic        held_v   = 1'b0;
    logic [WIDTH+1:0] held;
    logic        rnd_done;

    cla_pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
`ifdef CLA_SUBTRACT_EN
        ,
        .sub       (sub)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain modular arithmetic and sign-rule overflow.
    function automatic exp_t model(input logic [WIDTH-1:0] ma, mb,
                                   input logic mc, ms);
        exp_t             e;
        logic [WIDTH-1:0] beff;
        logic [WIDTH:0]   t;
        beff   = ms ? ~mb : mb;
        t      = {1'b0, ma} + {1'b0, beff} + {{WIDTH{1'b0}}, mc ^ ms};
        e.sum  = t[WIDTH-1:0];
        e.cout = t[WIDTH];
        e.ovf  = (ma[WIDTH-1] == beff[WIDTH-1]) && (t[WIDTH-1] != ma[WIDTH-1]);
        e.cyc  = 0;
        e.stl  = 0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [WIDTH-1:0] act, exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] ta, tbv, input logic tc, ts);
        int   n    = 0;
        logic done = 1'b0;
        exp_t e;
        in_valid = 1'b1;
        a        = ta;
        b        = tbv;
        c_in     = tc;
        sub      = ts;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                e     = model(ta, tbv, tc, ts);
                e.cyc = cyc;
                e.stl = stalls;
                q.push_back(e);
                done  = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 64) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout: in_ready stayed %b, expected 1", in_ready);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d results outstanding, expected 0", q.size());
        end
    endtask

    function automatic logic [WIDTH-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b0, {(WIDTH-1){1'b1}}};
            3:       return {1'b1, {(WIDTH-1){1'b0}}};
            default: return WIDTH'($urandom);
        endcase
    endfunction

    // Monitor: pops the scoreboard on every transfer, checks hold stability,
    // in_ready and latency (STAGES plus any stalled cycles in between).
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held_v = 1'b0;
        end else if (out_valid) begin
            if (held_v) begin
                checks++;
                if ({sum, c_out, ovf} !== held) begin
                    failures++;
                    $display("FAIL hold_stable: got %h expected %h", {sum, c_out, ovf}, held);
                end
            end
            checks++;
            if (in_ready !== out_ready) begin
                failures++;
                $display("FAIL in_ready_bp: got %b expected %b", in_ready, out_ready);
            end
            if (out_ready) begin
                held_v = 1'b0;
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output: got sum=%h with no result pending", sum);
                end else begin
                    e = q.pop_front();
                    if ({sum, c_out, ovf} !== {e.sum, e.cout, e.ovf}) begin
                        failures++;
                        $display("FAIL result: got sum=%h c_out=%b ovf=%b expected sum=%h c_out=%b ovf=%b",
                                 sum, c_out, ovf, e.sum, e.cout, e.ovf);
                    end
                    checks++;
                    if (cyc - e.cyc != STAGES + (stalls - e.stl)) begin
                        failures++;
                        $display("FAIL latency: got %0d expected %0d",
                                 cyc - e.cyc, STAGES + (stalls - e.stl));
                    end
                end
            end else begin
                held   = {sum, c_out, ovf};
                held_v = 1'b1;
                stalls++;
            end
        end else begin
            held_v = 1'b0;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL in_ready_empty: got %b expected 1", in_ready);
            end
        end
    end

    initial begin
        rnd_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", WIDTH'(out_valid), '0);
        chk("reset_sum", sum, '0);
        chk("reset_c_out", WIDTH'(c_out), '0);
        chk("reset_ovf", WIDTH'(ovf), '0);
        chk("reset_in_ready", WIDTH'(in_ready), WIDTH'(1));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(16'h00FF, 16'h0001, 1'b0, 1'b0);
        idle(4);
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h0000, 16'h0000, 1'b1, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        send(16'h8000, 16'h8000, 1'b0, 1'b0);
        send(16'h000F, 16'h0001, 1'b0, 1'b0);
`ifdef CLA_SUBTRACT_EN
        send(16'h0005, 16'h0007, 1'b0, 1'b1);
        send(16'h0007, 16'h0005, 1'b0, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
`endif
        idle(4);

        // Back-to-back stream with a 3-cycle consumer stall in the middle.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Random operands, random bubbles and random backpressure.
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    logic s;
`ifdef CLA_SUBTRACT_EN
                    s = 1'($urandom);
`else
                    s = 1'b0;
`endif
                    if ($urandom_range(0, 3) == 0) idle(1);
                    send(pick(), pick(), 1'($urandom), s);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two operations in flight: nothing may emerge afterwards.
        send(16'h1234, 16'h1111, 1'b0, 1'b0);
        send(16'hAAAA, 16'h5555, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", WIDTH'(out_valid), '0);
        q.delete();
        #2;
        rst_n = 1'b1;
        idle(6);
        chk("post_reset_out_valid", WIDTH'(out_valid), '0);
        send(16'h0001, 16'h0002, 1'b0, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
